// File: rtl/mdma_ram_ecc_pkg.sv
// SECDED helpers for the MDMA buffer RAMs: Hamming check bits at power-of-two
// positions plus one overall parity bit, sized for data words up to MAX_DW bits.
package mdma_ram_ecc_pkg;

    localparam int MAX_DW = 128;
    localparam int MAX_EW = 9;

    typedef struct packed {
        logic [MAX_DW-1:0] data;
        logic              sbe;
        logic              dbe;
    } dec_t;

    // Hamming bits plus the overall parity bit.
    function automatic int ecc_w(input int data_w);
        int r;
        r = 0;
        for (int i = MAX_EW - 1; i >= 1; i--)
            if ((1 << i) >= data_w + i + 1) r = i;
        return r + 1;
    endfunction

    function automatic logic is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Data bits fill the non-power-of-two codeword positions in ascending order.
    function automatic logic [MAX_EW-1:0] hamming(input logic [MAX_DW-1:0] d, input int data_w);
        logic [MAX_EW-1:0] c;
        int n;
        int di;
        n  = data_w + ecc_w(data_w) - 1;
        c  = '0;
        di = 0;
        for (int p = 1; p < MAX_DW + MAX_EW; p++) begin
            if (p <= n && !is_pow2(p)) begin
                if (d[di]) c = c ^ MAX_EW'(p);
                di++;
            end
        end
        return c;
    endfunction

    function automatic logic [MAX_EW-1:0] secded_enc(input logic [MAX_DW-1:0] d, input int data_w);
        logic [MAX_EW-1:0] c;
        c = hamming(d, data_w);
        c[ecc_w(data_w) - 1] = ^{d, c};
        return c;
    endfunction

    function automatic dec_t secded_dec(input logic [MAX_DW-1:0] d, input logic [MAX_EW-1:0] c,
                                        input int data_w);
        dec_t              res;
        logic [MAX_EW-1:0] syn;
        int                r;
        int                di;
        r        = ecc_w(data_w) - 1;
        syn      = (hamming(d, data_w) ^ c) & MAX_EW'((1 << r) - 1);
        res.data = d;
        res.sbe  = 1'b0;
        res.dbe  = 1'b0;
        di       = 0;
        if (^{d, c}) begin
            // Odd error count: repair data if the syndrome names a data position;
            // check/parity-bit hits need no data repair.
            res.sbe = 1'b1;
            for (int p = 1; p < MAX_DW + MAX_EW; p++) begin
                if (p <= data_w + r && !is_pow2(p)) begin
                    if (p == int'(syn)) res.data[di] = ~d[di];
                    di++;
                end
            end
        end else if (syn != '0) begin
            res.dbe = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mdma_sdp_ram_array.sv
// Plain simple-dual-port storage, read-first, registered read port; no reset
// on contents or read register so it maps onto block RAM.
module mdma_sdp_ram_array #(
    parameter int WIDTH  = 47,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [WIDTH-1:0]  wd_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] ra_i,
    output logic [WIDTH-1:0]  rd_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[wa_i] <= wd_i;
        if (re_i) rd_q <= mem[ra_i];
    end

    assign rd_o = rd_q;

endmodule

// File: rtl/mdma_sdp_ecc_ram.sv
// SECDED-protected SDP RAM: encode/inject on write, decode/correct on read,
// error counters and first-DBE address capture. MDMA_RAM_OUTREG_EN adds an output register.
module mdma_sdp_ecc_ram
    import mdma_ram_ecc_pkg::*;
#(
    parameter int DATA_W = 40,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] wadr,
    input  logic [DATA_W-1:0] wdat,
    input  logic              inj_sbe,
    input  logic              inj_dbe,
    input  logic              ren,
    input  logic [ADDR_W-1:0] radr,
    output logic [DATA_W-1:0] rdat,
    output logic              rvld,
    output logic              rsbe,
    output logic              rdbe,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  sbe_cnt,
    output logic [CNT_W-1:0]  dbe_cnt,
    output logic [ADDR_W-1:0] dbe_adr,
    output logic              dbe_adr_vld
);

    localparam int ECC_W = ecc_w(DATA_W);
    localparam int CW    = DATA_W + ECC_W;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    logic              wr_ok, rd_ok;
    logic [MAX_EW-1:0] wr_ecc;
    logic [CW-1:0]     inj_mask, wr_cw, rd_cw;
    logic              rd_vld_q, rd_oor_q;
    logic [ADDR_W-1:0] rd_adr_q;
    dec_t              dec;
    logic [DATA_W-1:0] s1_dat;
    logic              s1_sbe, s1_dbe;
    logic              ev_vld, ev_sbe, ev_dbe;
    logic [ADDR_W-1:0] ev_adr;
    logic [CNT_W-1:0]  sbe_cnt_q, sbe_cnt_d, dbe_cnt_q, dbe_cnt_d;
    logic [ADDR_W-1:0] dbe_adr_q, dbe_adr_d;
    logic              dbe_vld_q, dbe_vld_d;

    assign wr_ok    = wen && ({1'b0, wadr} < DEPTH_A);
    assign rd_ok    = ren && ({1'b0, radr} < DEPTH_A);
    assign wr_ecc   = secded_enc(MAX_DW'(wdat), DATA_W);
    assign inj_mask = inj_dbe ? CW'(3) : (inj_sbe ? CW'(1) : '0);
    assign wr_cw    = {wr_ecc[ECC_W-1:0], wdat} ^ inj_mask;

    mdma_sdp_ram_array #(.WIDTH(CW), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
        .clk  (clk),
        .we_i (wr_ok),
        .wa_i (wadr),
        .wd_i (wr_cw),
        .re_i (rd_ok),
        .ra_i (radr),
        .rd_o (rd_cw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_oor_q <= 1'b0;
            rd_adr_q <= '0;
        end else begin
            rd_vld_q <= ren;
            if (ren) begin
                rd_oor_q <= !rd_ok;
                rd_adr_q <= radr;
            end
        end
    end

    assign dec    = secded_dec(MAX_DW'(rd_cw[DATA_W-1:0]), MAX_EW'(rd_cw[CW-1:DATA_W]), DATA_W);
    assign s1_dat = rd_oor_q ? '0 : dec.data[DATA_W-1:0];
    assign s1_sbe = rd_vld_q && !rd_oor_q && dec.sbe;
    assign s1_dbe = rd_vld_q && !rd_oor_q && dec.dbe;

`ifdef MDMA_RAM_OUTREG_EN
    logic              o_vld_q, o_sbe_q, o_dbe_q;
    logic [DATA_W-1:0] o_dat_q;
    logic [ADDR_W-1:0] o_adr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld_q <= 1'b0;
            o_sbe_q <= 1'b0;
            o_dbe_q <= 1'b0;
            o_dat_q <= '0;
            o_adr_q <= '0;
        end else begin
            o_vld_q <= rd_vld_q;
            o_sbe_q <= s1_sbe;
            o_dbe_q <= s1_dbe;
            if (rd_vld_q) begin
                o_dat_q <= s1_dat;
                o_adr_q <= rd_adr_q;
            end
        end
    end

    assign ev_vld = o_vld_q;
    assign ev_sbe = o_sbe_q;
    assign ev_dbe = o_dbe_q;
    assign ev_adr = o_adr_q;
    assign rdat   = o_dat_q;
`else
    // The array register is not reset, so idle cycles show the last delivered word.
    logic [DATA_W-1:0] hold_q;

    always_ff @(posedge clk) begin
        if (rst)           hold_q <= '0;
        else if (rd_vld_q) hold_q <= s1_dat;
    end

    assign ev_vld = rd_vld_q;
    assign ev_sbe = s1_sbe;
    assign ev_dbe = s1_dbe;
    assign ev_adr = rd_adr_q;
    assign rdat   = rd_vld_q ? s1_dat : hold_q;
`endif

    // A read landing while rst is high is discarded, so the strobe is masked too.
    assign rvld = ev_vld && !rst;
    assign rsbe = ev_sbe && !rst;
    assign rdbe = ev_dbe && !rst;

    always_comb begin
        sbe_cnt_d = sbe_cnt_q;
        dbe_cnt_d = dbe_cnt_q;
        dbe_adr_d = dbe_adr_q;
        dbe_vld_d = dbe_vld_q;
        if (err_clr) begin
            sbe_cnt_d = '0;
            dbe_cnt_d = '0;
            dbe_adr_d = '0;
            dbe_vld_d = 1'b0;
        end else begin
            if (ev_sbe && sbe_cnt_q != '1) sbe_cnt_d = sbe_cnt_q + 1'b1;
            if (ev_dbe) begin
                if (dbe_cnt_q != '1) dbe_cnt_d = dbe_cnt_q + 1'b1;
                if (!dbe_vld_q) begin
                    dbe_adr_d = ev_adr;
                    dbe_vld_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sbe_cnt_q <= '0;
            dbe_cnt_q <= '0;
            dbe_adr_q <= '0;
            dbe_vld_q <= 1'b0;
        end else begin
            sbe_cnt_q <= sbe_cnt_d;
            dbe_cnt_q <= dbe_cnt_d;
            dbe_adr_q <= dbe_adr_d;
            dbe_vld_q <= dbe_vld_d;
        end
    end

    assign sbe_cnt     = sbe_cnt_q;
    assign dbe_cnt     = dbe_cnt_q;
    assign dbe_adr     = dbe_adr_q;
    assign dbe_adr_vld = dbe_vld_q;

endmodule

// File: tb/tb_mdma_sdp_ecc_ram.sv
// Scoreboard bench for mdma_sdp_ecc_ram: directed cases plus random traffic against
// a word-level memory model; latency follows MDMA_RAM_OUTREG_EN.
module tb_mdma_sdp_ecc_ram;

    localparam int DW    = 40;
    localparam int DEPTH = 500;
    localparam int AW    = 9;
    localparam int CNTW  = 2;
    localparam int CMAX  = (1 << CNTW) - 1;
`ifdef MDMA_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wen = 1'b0, inj_sbe = 1'b0, inj_dbe = 1'b0, ren = 1'b0, err_clr = 1'b0;
    logic [AW-1:0] wadr = '0, radr = '0;
    logic [DW-1:0] wdat = '0;
    logic [DW-1:0] rdat;
    logic          rvld, rsbe, rdbe, dbe_adr_vld;
    logic [CNTW-1:0] sbe_cnt, dbe_cnt;
    logic [AW-1:0] dbe_adr;

    mdma_sdp_ecc_ram #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CNTW)) dut (
        .clk(clk), .rst(rst), .wen(wen), .wadr(wadr), .wdat(wdat),
        .inj_sbe(inj_sbe), .inj_dbe(inj_dbe), .ren(ren), .radr(radr),
        .rdat(rdat), .rvld(rvld), .rsbe(rsbe), .rdbe(rdbe), .err_clr(err_clr),
        .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt), .dbe_adr(dbe_adr), .dbe_adr_vld(dbe_adr_vld)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] dat;
        bit            sbe;
        bit            dbe;
        int            adr;
        int            due;
    } exp_t;

    typedef struct {
        logic [DW-1:0] dat;
        int            kind;   // 0 clean, 1 single-bit injected, 2 double-bit injected
    } ent_t;

    exp_t sbq[$];
    ent_t mem_m[int];
    int   written[$];
    int   checks = 0, failures = 0;
    int   m_sbe = 0, m_dbe = 0, m_adr = 0;
    bit   m_adrv = 1'b0;
    logic [DW-1:0] m_last = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd_dat();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // One clock of stimulus; the expected read result is taken before the write lands.
    task automatic step(input bit w, input int wa, input logic [DW-1:0] wd, input int inj,
                        input bit r, input int ra, input bit clr, input bit rs);
        exp_t e;
        @(posedge clk);
        #1;
        wen = w; wadr = AW'(wa); wdat = wd;
        inj_sbe = (inj == 1); inj_dbe = (inj == 2);
        ren = r; radr = AW'(ra); err_clr = clr; rst = rs;
        if (r && !rs) begin
            e.due = cyc + LAT;
            e.adr = ra;
            e.dat = '0; e.sbe = 1'b0; e.dbe = 1'b0;
            if (ra < DEPTH && mem_m.exists(ra)) begin
                e.sbe = (mem_m[ra].kind == 1);
                e.dbe = (mem_m[ra].kind == 2);
                e.dat = e.dbe ? (mem_m[ra].dat ^ DW'(3)) : mem_m[ra].dat;
            end
            sbq.push_back(e);
        end
        if (w && !rs && wa < DEPTH) begin
            if (!mem_m.exists(wa)) written.push_back(wa);
            mem_m[wa] = '{wd, inj};
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input int inj);
        step(1, a, d, inj, 0, 0, 0, 0);
    endtask

    task automatic rd(input int a);
        step(0, 0, '0, 0, 1, a, 0, 0);
    endtask

    // Monitor: compares every presented read and the error-status outputs each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("sbe_cnt", 64'(sbe_cnt), 64'(m_sbe));
            chk("dbe_cnt", 64'(dbe_cnt), 64'(m_dbe));
            chk("dbe_adr_vld", 64'(dbe_adr_vld), 64'(m_adrv));
            chk("dbe_adr", 64'(dbe_adr), 64'(m_adr));
            if (rst) begin
                chk("rvld_in_rst", 64'(rvld), 64'd0);
                sbq.delete();
                m_sbe = 0; m_dbe = 0; m_adr = 0; m_adrv = 1'b0; m_last = '0;
            end else begin
                while (sbq.size() > 0 && sbq[0].due < cyc) begin
                    e = sbq.pop_front();
                    chk("missing_rvld_adr", 64'(e.adr), 64'hFFFF);
                end
                if (rvld) begin
                    if (sbq.size() == 0 || sbq[0].due != cyc) begin
                        chk("unexpected_rvld", 64'(rvld), 64'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("rdat", 64'(rdat), 64'(e.dat));
                        chk("rsbe", 64'(rsbe), 64'(e.sbe));
                        chk("rdbe", 64'(rdbe), 64'(e.dbe));
                        m_last = e.dat;
                        if (!err_clr) begin
                            if (e.sbe && m_sbe < CMAX) m_sbe++;
                            if (e.dbe) begin
                                if (m_dbe < CMAX) m_dbe++;
                                if (!m_adrv) begin
                                    m_adr  = e.adr;
                                    m_adrv = 1'b1;
                                end
                            end
                        end
                    end
                end else begin
                    chk("idle_rsbe", 64'(rsbe), 64'd0);
                    chk("idle_rdbe", 64'(rdbe), 64'd0);
                    chk("idle_rdat_hold", 64'(rdat), 64'(m_last));
                end
                if (err_clr) begin
                    m_sbe = 0; m_dbe = 0; m_adr = 0; m_adrv = 1'b0;
                end
            end
        end
    end

    initial begin
        int ra, wa, inj;
        // reset
        step(0, 0, '0, 0, 0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 0, 0, 0);
        chk("reset_rvld", 64'(rvld), 64'd0);
        chk("reset_rdat", 64'(rdat), 64'd0);

        // clean write/read
        wr(5, 40'h12_3456_789A, 0);
        rd(5);
        idle(LAT + 1);

        // single-bit injection is corrected and counted
        wr(10, 40'hFF_0000_FFFF, 1);
        rd(10);
        idle(LAT + 1);
        chk("t2_sbe_cnt", 64'(sbe_cnt), 64'd1);

        // double-bit injection: raw data, first address captured
        wr(20, 40'h01_2345_6789, 2);
        wr(30, 40'hAB_CDEF_0123, 2);
        rd(30);
        rd(20);
        idle(LAT + 1);
        chk("t3_dbe_cnt", 64'(dbe_cnt), 64'd2);
        chk("t3_dbe_adr", 64'(dbe_adr), 64'd30);
        chk("t3_dbe_vld", 64'(dbe_adr_vld), 64'd1);

        // read-first on same-cycle collision
        wr(7, 40'hAA, 0);
        step(1, 7, 40'h55, 0, 1, 7, 0, 0);
        rd(7);
        idle(LAT + 1);

        // out-of-range addresses (DEPTH is not a power of two)
        wr(505, 40'hDE_ADBE_EF00, 0);
        rd(505);
        wr(499, 40'h99_8877_6655, 0);
        rd(499);
        idle(LAT + 1);

        // SBE counter saturation
        for (int i = 0; i < 4; i++) rd(10);
        idle(LAT + 1);
        chk("t5_sbe_sat", 64'(sbe_cnt), 64'(CMAX));

        // err_clr coincident with a DBE event drops the event
        step(0, 0, '0, 0, 0, 0, 1, 0);
        rd(20);
        idle(LAT - 1);
        step(0, 0, '0, 0, 0, 0, 1, 0);
        idle(2);
        chk("t5_clr_dbe_cnt", 64'(dbe_cnt), 64'd0);
        chk("t5_clr_dbe_vld", 64'(dbe_adr_vld), 64'd0);

        // reset the cycle after a read: the read never completes
        rd(5);
        step(0, 0, '0, 0, 0, 0, 0, 1);
        idle(LAT + 2);
        chk("t6_no_rvld", 64'(rvld), 64'd0);
        rd(5);
        step(0, 0, '0, 0, 0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 0, 0, 1);
        idle(LAT + 2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            wa  = $urandom_range(0, 511);
            inj = ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 5) == 0) ? 2 : 0);
            ra  = ($urandom_range(0, 7) == 0) ? $urandom_range(500, 511)
                                              : written[$urandom_range(0, written.size() - 1)];
            step($urandom_range(0, 1), wa, rnd_dat(), inj, $urandom_range(0, 2) != 0, ra,
                 $urandom_range(0, 24) == 0, 1'b0);
        end

        idle(LAT + 3);
        chk("drain_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
